// File: rtl/issue_scoreboard_pkg.sv
// issue_scoreboard_pkg: shared state encoding and default sizing for the decode issue scoreboard
package issue_scoreboard_pkg;
  typedef enum logic [1:0] {RUN, STALL_RAW, DRAIN, FLUSH} scb_state_t;
  localparam int SCB_MAX_INFLIGHT = 3;
  localparam int SCB_TIMEOUT = 1024;
endpackage

// File: rtl/issue_scoreboard_pending_table.sv
// issue_scoreboard_pending_table: per-register outstanding long-latency write counters
// x0 never counts; read ports see a same-cycle completion of the last outstanding write
module issue_scoreboard_pending_table
  import issue_scoreboard_pkg::*;
#(
  parameter int MAX_INFLIGHT = SCB_MAX_INFLIGHT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc_en,
  input  logic [4:0] inc_wd,
  input  logic       dec_en,
  input  logic [4:0] dec_wd,
  input  logic [4:0] rd0_addr,
  output logic       rd0_hz,
  input  logic [4:0] rd1_addr,
  output logic       rd1_hz,
  input  logic [4:0] chk_wd,
  output logic       full,
  output logic       busy
);
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic [31:0] nz, inc_hit, dec_hit;
  always_comb begin
    for (int i = 0; i < 32; i++) nz[i] = cnt_q[i] != '0;
  end
  assign inc_hit = (32'(inc_en) << inc_wd) & ~32'd1;
  assign dec_hit = (32'(dec_en) << dec_wd) & nz;
  always_comb begin
    for (int i = 0; i < 32; i++)
      cnt_d[i] = (inc_hit[i] & ~dec_hit[i]) ? cnt_q[i] + CNT_W'(1)
               : (dec_hit[i] & ~inc_hit[i]) ? cnt_q[i] - CNT_W'(1) : cnt_q[i];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
    else cnt_q <= cnt_d;
  end
  assign rd0_hz = nz[rd0_addr] & ~(dec_en & dec_wd == rd0_addr & cnt_q[rd0_addr] == CNT_W'(1));
  assign rd1_hz = nz[rd1_addr] & ~(dec_en & dec_wd == rd1_addr & cnt_q[rd1_addr] == CNT_W'(1));
  assign full = cnt_q[chk_wd] == CNT_W'(MAX_INFLIGHT);
  assign busy = |nz;
endmodule

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: decode-stage issue/stall control with long-latency RAW tracking, drain and flush
// ISSUE_SCB_STATS_EN adds the saturating stall_cycles counter and port
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int MAX_INFLIGHT = SCB_MAX_INFLIGHT,
  parameter int TIMEOUT = SCB_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] id_wd,
  input  logic       id_is_wb,
  input  logic       id_long_lat,
  input  logic       id_serialize,
  input  logic       ex_ready,
  input  logic       jump_en,
  input  logic       wb_valid,
  input  logic [4:0] wb_wd,
  output logic       issue,
  output logic       stall,
  output logic       busy,
  output logic       hang
`ifdef ISSUE_SCB_STATS_EN
  ,output logic [31:0] stall_cycles
`endif
);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  scb_state_t state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic hang_q, hang_d;
  logic rd0_hz, rd1_hz, full, raw, sat, ser, hz;
  issue_scoreboard_pending_table #(.MAX_INFLIGHT(MAX_INFLIGHT)) u_pt (
    .clk(clk), .rst_n(rst_n),
    .inc_en(issue & id_is_wb & id_long_lat), .inc_wd(id_wd),
    .dec_en(wb_valid), .dec_wd(wb_wd),
    .rd0_addr(id_rs1), .rd0_hz(rd0_hz),
    .rd1_addr(id_rs2), .rd1_hz(rd1_hz),
    .chk_wd(id_wd), .full(full), .busy(busy)
  );
  assign raw = (id_use_rs1 & rd0_hz) | (id_use_rs2 & rd1_hz);
  assign sat = id_is_wb & id_long_lat & full;
  assign ser = id_serialize & busy;
  assign hz = id_valid & (raw | sat);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      wd_q <= '0;
      hang_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q <= wd_d;
      hang_q <= hang_d;
    end
  end
  always_comb begin
    state_d = jump_en ? FLUSH
            : state_q == FLUSH ? RUN
            : state_q == RUN ? ((id_valid & ser) ? DRAIN : hz ? STALL_RAW : RUN)
            : state_q == STALL_RAW ? (hz ? STALL_RAW : RUN)
            : busy ? DRAIN : RUN;
  end
  always_comb begin
    issue = id_valid & ex_ready & ~jump_en & (state_q != FLUSH) & ~raw & ~sat & ~ser;
    stall = id_valid & ~jump_en & ~issue;
  end
  // watchdog counts only consecutive stalls; hang latches until reset
  always_comb begin
    wd_d = ~stall ? '0 : (wd_q == WD_W'(TIMEOUT)) ? wd_q : wd_q + WD_W'(1);
    hang_d = hang_q | (stall & wd_q == WD_W'(TIMEOUT - 1));
  end
  assign hang = hang_q;
`ifdef ISSUE_SCB_STATS_EN
  logic [31:0] sc_q, sc_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sc_q <= '0;
    else sc_q <= sc_d;
  end
  always_comb sc_d = (stall & ~&sc_q) ? sc_q + 32'd1 : sc_q;
  assign stall_cycles = sc_q;
`endif
endmodule

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard: directed scenarios plus random traffic against a queue-free reference model
// ISSUE_SCB_STATS_EN also checks stall_cycles
module tb_issue_scoreboard;
  localparam int MAXF = 3;
  localparam int TMO = 16;
  logic clk = 0, rst_n = 0;
  logic id_valid, id_use_rs1, id_use_rs2, id_is_wb, id_long_lat, id_serialize;
  logic [4:0] id_rs1, id_rs2, id_wd, wb_wd;
  logic ex_ready, jump_en, wb_valid;
  logic issue, stall, busy, hang;
  logic [31:0] stall_cycles;
  int n_chk = 0, n_pass = 0;
  int pend [32];
  bit m_flush, m_hang;
  int m_wd, m_sc;
  always #5 clk = ~clk;
  issue_scoreboard #(.MAX_INFLIGHT(MAXF), .TIMEOUT(TMO)) dut (
`ifdef ISSUE_SCB_STATS_EN
    .stall_cycles(stall_cycles),
`endif
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_wd(id_wd), .id_is_wb(id_is_wb),
    .id_long_lat(id_long_lat), .id_serialize(id_serialize), .ex_ready(ex_ready),
    .jump_en(jump_en), .wb_valid(wb_valid), .wb_wd(wb_wd), .issue(issue), .stall(stall),
    .busy(busy), .hang(hang)
  );
`ifndef ISSUE_SCB_STATS_EN
  assign stall_cycles = '0;
`endif
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask
  task automatic put(input logic v, input int r1, input logic u1, input int r2, input logic u2,
                     input int wd, input logic wb, input logic ll, input logic sz);
    id_valid = v; id_rs1 = 5'(r1); id_use_rs1 = u1; id_rs2 = 5'(r2); id_use_rs2 = u2;
    id_wd = 5'(wd); id_is_wb = wb; id_long_lat = ll; id_serialize = sz;
  endtask
  task automatic wb(input logic v, input int wd);
    wb_valid = v; wb_wd = 5'(wd);
  endtask
  task automatic idle();
    put(0, 0, 0, 0, 0, 0, 0, 0, 0); wb(0, 0); ex_ready = 1; jump_en = 0;
  endtask
  task automatic model_clear();
    for (int i = 0; i < 32; i++) pend[i] = 0;
    m_flush = 0; m_hang = 0; m_wd = 0; m_sc = 0;
  endtask
  // one clock: predict at negedge from the rules, then advance the model across posedge
  task automatic cyc();
    bit bsy, r1h, r2h, raw, sat, ser, iss, stl, dec_ok;
    @(negedge clk);
    bsy = 0;
    for (int i = 0; i < 32; i++) if (pend[i] != 0) bsy = 1;
    r1h = pend[id_rs1] != 0 && !(wb_valid && wb_wd == id_rs1 && pend[id_rs1] == 1);
    r2h = pend[id_rs2] != 0 && !(wb_valid && wb_wd == id_rs2 && pend[id_rs2] == 1);
    raw = (id_use_rs1 && r1h) || (id_use_rs2 && r2h);
    sat = id_is_wb && id_long_lat && pend[id_wd] == MAXF;
    ser = id_serialize && bsy;
    iss = id_valid && ex_ready && !jump_en && !m_flush && !raw && !sat && !ser;
    stl = id_valid && !jump_en && !iss;
    chk("issue", 32'(issue), 32'(iss));
    chk("stall", 32'(stall), 32'(stl));
    chk("busy", 32'(busy), 32'(bsy));
    chk("hang", 32'(hang), 32'(m_hang));
`ifdef ISSUE_SCB_STATS_EN
    chk("stall_cycles", stall_cycles, 32'(m_sc));
`endif
    dec_ok = wb_valid && pend[wb_wd] != 0;
    if (iss && id_is_wb && id_long_lat && id_wd != 0) pend[id_wd]++;
    if (dec_ok) pend[wb_wd]--;
    m_flush = jump_en;
    m_wd = stl ? m_wd + 1 : 0;
    if (m_wd >= TMO) m_hang = 1;
    if (stl) m_sc++;
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    rst_n = 0; idle(); model_clear();
    #2;
    chk("rst_issue", 32'(issue), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_hang", 32'(hang), 0);
`ifdef ISSUE_SCB_STATS_EN
    chk("rst_stall_cycles", stall_cycles, 0);
`endif
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask
  initial begin
    idle();
    do_reset();
    // load x5, dependent use stalls until its writeback, issuing in the wb cycle
    put(1, 0, 0, 0, 0, 5, 1, 1, 0); cyc();
    put(1, 5, 1, 0, 0, 6, 1, 0, 0); repeat (3) cyc();
    wb(1, 5); cyc(); wb(0, 0);
    // saturate x7, fourth write waits for one completion
    put(1, 0, 0, 0, 0, 7, 1, 1, 0); repeat (4) cyc();
    wb(1, 7); cyc(); wb(0, 0); cyc();
    put(0, 0, 0, 0, 0, 0, 0, 0, 0);
    wb(1, 7); repeat (3) cyc(); wb(0, 0);
    // issue to x9 while its single outstanding write completes
    put(1, 0, 0, 0, 0, 9, 1, 1, 0); cyc();
    wb(1, 9); cyc(); wb(0, 0);
    put(1, 9, 1, 0, 0, 1, 1, 0, 0); cyc();
    wb(1, 9); cyc(); wb(0, 0); cyc();
    // serialise behind two outstanding loads
    put(1, 0, 0, 0, 0, 3, 1, 1, 0); cyc();
    put(1, 0, 0, 0, 0, 4, 1, 1, 0); cyc();
    put(1, 0, 0, 0, 0, 0, 0, 0, 1); repeat (2) cyc();
    wb(1, 3); cyc(); wb(0, 0); cyc();
    wb(1, 4); cyc(); wb(0, 0); cyc();
    // redirect while RAW-stalled
    put(1, 0, 0, 0, 0, 5, 1, 1, 0); cyc();
    put(1, 0, 0, 5, 1, 2, 1, 0, 0); repeat (2) cyc();
    jump_en = 1; cyc(); jump_en = 0;
    repeat (2) cyc();
    wb(1, 5); cyc(); wb(0, 0);
    // random traffic on a small register window to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      put($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 1),
          $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
          $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, $urandom_range(0, 19) == 0);
      ex_ready = $urandom_range(0, 19) < 17;
      jump_en = $urandom_range(0, 19) == 0;
      wb($urandom_range(0, 9) < 5, $urandom_range(0, 7));
      if (n == 1500) begin
        rst_n = 0; #1 model_clear(); #1 rst_n = 1;
      end
      cyc();
    end
    // watchdog: RAW stall with no writeback
    do_reset();
    put(1, 0, 0, 0, 0, 5, 1, 1, 0); cyc();
    put(1, 5, 1, 0, 0, 6, 1, 0, 0); repeat (TMO + 4) cyc();
    chk("hang_set", 32'(hang), 1);
    do_reset();
    put(0, 0, 0, 0, 0, 0, 0, 0, 0); wb(1, 5); cyc();
    put(1, 5, 1, 0, 0, 6, 1, 0, 0); wb(0, 0); cyc();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
